stopwatch_mode_ctrl: RTL and testbench

Mode controller for the lab stopwatch. It debounces the three raw push-buttons (start_stop, set, change) and runs the RUN/STOP/EDIT state machine. It generates the 0.01 s count tick and issues clear, digit-select and increment commands to the BCD counter/display datapath. It sits between the board buttons and the stopwatch counter chain.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_mode_ctrl_if.sv | 20 ++
 rtl/stopwatch_mode_ctrl_debouncer.sv | 35 +++
 rtl/stopwatch_mode_ctrl.sv | 98 +++++++++
 tb/tb_stopwatch_mode_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit one-hot constants and counter-width helpers for the stopwatch mode controller.
package stopwatch_pkg;
  typedef enum logic [2:0] {STOP, RUN, EDIT0, EDIT1, EDIT2, EDIT3} state_t;
  localparam logic [3:0] DIG0 = 4'b0001;
  localparam logic [3:0] DIG1 = 4'b0010;
  localparam logic [3:0] DIG2 = 4'b0100;
  localparam logic [3:0] DIG3 = 4'b1000;
  localparam int PULSE_MAX_DEF = 1_000_000;
  localparam int DB_CYCLES_DEF = 50_000;
  localparam int BLINK_MAX_DEF = 25_000_000;
  localparam int PULSE_W_DEF = $clog2(PULSE_MAX_DEF);
  localparam int DB_W_DEF = $clog2(DB_CYCLES_DEF);
  localparam int BLINK_W_DEF = $clog2(BLINK_MAX_DEF);
  // a modulo-n counter needs at least one bit even when n is 1
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic is_edit(input state_t s);
    return s inside {EDIT0, EDIT1, EDIT2, EDIT3};
  endfunction
  function automatic logic [3:0] dig(input state_t s);
    return s == EDIT0 ? DIG0 : s == EDIT1 ? DIG1 : s == EDIT2 ? DIG2 : s == EDIT3 ? DIG3 : 4'b0000;
  endfunction
endpackage

// File: rtl/stopwatch_mode_ctrl_if.sv
// stopwatch_mode_ctrl_if: raw buttons in, datapath commands out; master = mode controller, slave = board/datapath side.
interface stopwatch_mode_ctrl_if;
  logic start_stop_i;
  logic set_i;
  logic change_i;
  logic tick_o;
  logic run_o;
  logic clr_o;
  logic [3:0] edit_o;
  logic inc_o;
  logic blink_o;
  modport master(
    input  start_stop_i, set_i, change_i,
    output tick_o, run_o, clr_o, edit_o, inc_o, blink_o
  );
  modport slave(
    output start_stop_i, set_i, change_i,
    input  tick_o, run_o, clr_o, edit_o, inc_o, blink_o
  );
endinterface

// File: rtl/stopwatch_mode_ctrl_debouncer.sv
// button_debouncer: 2-FF synchronizer plus stability counter on an active-low button; press is a one-cycle pulse on the accepted 1->0 change.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 50_000
) (
  input  logic clk100_i,
  input  logic rstn,
  input  logic btn_n,
  output logic press
);
  localparam int W = cnt_w(DB_CYCLES);
  logic [1:0] sync;
  logic level;
  logic [W-1:0] cnt;
  // cnt holds how many consecutive synchronized samples have disagreed with level
  always_ff @(posedge clk100_i or posedge rstn)
    if (rstn) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] == level)
        cnt <= '0;
      else if (cnt == W'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= level;
      end else
        cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// stopwatch_mode_ctrl: debounced RUN/STOP/EDIT mode FSM, 0.01 s tick prescaler and digit-edit commands for the stopwatch datapath.
// Define STOPWATCH_BLINK_EN to build the edited-digit blink generator; otherwise blink_o is tied low.
module stopwatch_mode_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PULSE_MAX = 1_000_000,
  parameter int DB_CYCLES = 50_000,
  parameter int BLINK_MAX = 25_000_000
) (
  input logic clk100_i,
  input logic rstn,
  stopwatch_mode_ctrl_if.master io
);
  localparam int PW = cnt_w(PULSE_MAX);
  if (PULSE_MAX < 1 || DB_CYCLES < 1 || BLINK_MAX < 1)
    $error("stopwatch_mode_ctrl: PULSE_MAX, DB_CYCLES and BLINK_MAX must be >= 1");
  state_t state, nxt;
  logic ev_ss, ev_set, ev_chg;
  logic ss, st, ch;
  logic [PW-1:0] presc, presc_n;
  logic tick_n, run_n, clr_n, inc_n;
  logic [3:0] edit_n;
  logic tick_q, run_q, clr_q, inc_q;
  logic [3:0] edit_q;
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk100_i(clk100_i), .rstn(rstn), .btn_n(io.start_stop_i), .press(ev_ss)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk100_i(clk100_i), .rstn(rstn), .btn_n(io.set_i), .press(ev_set)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_chg (
    .clk100_i(clk100_i), .rstn(rstn), .btn_n(io.change_i), .press(ev_chg)
  );
  // simultaneous presses: start_stop beats set beats change, losers are dropped
  assign ss = ev_ss;
  assign st = ev_set & ~ev_ss;
  assign ch = ev_chg & ~ev_ss & ~ev_set;
  always_comb
    nxt = state == STOP ? (ss ? RUN : st ? EDIT0 : STOP)
        : state == RUN  ? (ss ? STOP : RUN)
        : !st           ? state
        : state == EDIT3 ? STOP : state_t'(state + 3'd1);
  // outputs are computed from the next state so they register alongside it
  always_comb begin
    run_n   = nxt == RUN;
    edit_n  = dig(nxt);
    clr_n   = state == STOP && ch;
    inc_n   = is_edit(state) && ch;
    presc_n = (state == RUN && nxt == RUN) ? (presc == PW'(PULSE_MAX - 1) ? '0 : presc + 1'b1) : '0;
    tick_n  = run_n && presc_n == PW'(PULSE_MAX - 1);
  end
  always_ff @(posedge clk100_i or posedge rstn)
    if (rstn) begin
      state  <= STOP;
      presc  <= '0;
      tick_q <= 1'b0;
      run_q  <= 1'b0;
      clr_q  <= 1'b0;
      inc_q  <= 1'b0;
      edit_q <= 4'b0000;
    end else begin
      state  <= nxt;
      presc  <= presc_n;
      tick_q <= tick_n;
      run_q  <= run_n;
      clr_q  <= clr_n;
      inc_q  <= inc_n;
      edit_q <= edit_n;
    end
  assign io.tick_o = tick_q;
  assign io.run_o  = run_q;
  assign io.clr_o  = clr_q;
  assign io.inc_o  = inc_q;
  assign io.edit_o = edit_q;
`ifdef STOPWATCH_BLINK_EN
  localparam int BW = cnt_w(BLINK_MAX);
  logic [BW-1:0] bcnt;
  logic blink_q;
  // any entry into an EDIT state, including EDITn -> EDITn+1, restarts the blink phase lit
  always_ff @(posedge clk100_i or posedge rstn)
    if (rstn) begin
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else if (!is_edit(nxt)) begin
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else if (nxt != state) begin
      bcnt    <= '0;
      blink_q <= 1'b1;
    end else begin
      bcnt    <= bcnt == BW'(BLINK_MAX - 1) ? '0 : bcnt + 1'b1;
      blink_q <= blink_q ^ (bcnt == BW'(BLINK_MAX - 1));
    end
  assign io.blink_o = blink_q;
`else
  assign io.blink_o = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// tb_stopwatch_mode_ctrl: directed button scenarios, a window-based behavioural model checked every cycle, and literal timing pins.
module tb_stopwatch_mode_ctrl;
  localparam int P = 2;
  localparam int DB = 4;
  localparam int B = 3;
`ifdef STOPWATCH_BLINK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b1;
  stopwatch_mode_ctrl_if bus();
  stopwatch_mode_ctrl #(.PULSE_MAX(P), .DB_CYCLES(DB), .BLINK_MAX(B)) dut (
    .clk100_i(clk), .rstn(rstn), .io(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int ntick = 0, nclr = 0, ninc = 0;
  bit m_run = 0, m_clr = 0, m_inc = 0, m_tick = 0, m_blink = 0;
  bit ent_run, ent_edit, ss, st, ch, diff;
  int m_dig = -1, rk = 0, bk = 0;
  bit lvl[3], pend[3], raw[3];
  bit hist[3][DB+2];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic int z(input bit v);
    return rstn ? 0 : int'(v);
  endfunction
  // Model: a button's level flips once the last DB synchronized samples (raw delayed 2) all oppose it;
  // a flip to 0 is a press that acts on the following edge.
  always @(posedge clk) begin
    raw[0] = bus.start_stop_i;
    raw[1] = bus.set_i;
    raw[2] = bus.change_i;
    if (rstn) begin
      m_run = 0; m_dig = -1; m_clr = 0; m_inc = 0; m_tick = 0; m_blink = 0;
      for (int b = 0; b < 3; b++) begin
        lvl[b] = 1; pend[b] = 0;
        for (int i = 0; i < DB + 2; i++) hist[b][i] = 1;
      end
    end else begin
      ss = pend[0];
      st = pend[1] && !pend[0];
      ch = pend[2] && !pend[1] && !pend[0];
      m_clr = 0; m_inc = 0; ent_run = 0; ent_edit = 0;
      if (m_run) begin
        if (ss) m_run = 0;
      end else if (m_dig >= 0) begin
        if (st) begin
          m_dig = m_dig == 3 ? -1 : m_dig + 1;
          ent_edit = m_dig >= 0;
        end else if (ch) m_inc = 1;
      end else begin
        if (ss) begin m_run = 1; ent_run = 1; end
        else if (st) begin m_dig = 0; ent_edit = 1; end
        else if (ch) m_clr = 1;
      end
      rk = ent_run ? 0 : rk + 1;
      m_tick = m_run && ((rk + 1) % P == 0);
      bk = ent_edit ? 0 : bk + 1;
      m_blink = m_dig >= 0 && ((bk / B) % 2 == 0);
      for (int b = 0; b < 3; b++) begin
        for (int i = DB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw[b];
        diff = 1;
        for (int i = 2; i < DB + 2; i++) if (hist[b][i] == lvl[b]) diff = 0;
        if (diff) begin lvl[b] = !lvl[b]; pend[b] = !lvl[b]; end
        else pend[b] = 0;
      end
    end
  end
  always @(negedge clk) begin
    chk("tick", int'(bus.tick_o), z(m_tick));
    chk("run", int'(bus.run_o), z(m_run));
    chk("clr", int'(bus.clr_o), z(m_clr));
    chk("inc", int'(bus.inc_o), z(m_inc));
    chk("edit", int'(bus.edit_o), rstn || m_dig < 0 ? 0 : 1 << m_dig);
    chk("blink", int'(bus.blink_o), BL ? z(m_blink) : 0);
    ntick += int'(bus.tick_o);
    nclr  += int'(bus.clr_o);
    ninc  += int'(bus.inc_o);
  end
  task automatic setb(input int b, input logic v);
    if (b == 0) bus.start_stop_i = v;
    else if (b == 1) bus.set_i = v;
    else bus.change_i = v;
  endtask
  task automatic hold(input int b, input int n);
    @(negedge clk);
    setb(b, 1'b0);
    repeat (n) @(negedge clk);
    setb(b, 1'b1);
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int c0, i0, t0;
    bit found;
    int exp_edit[4] = '{2, 4, 8, 0};
    bus.start_stop_i = 1'b1;
    bus.set_i = 1'b1;
    bus.change_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_run", int'(bus.run_o), 0);
    chk("rst_tick", int'(bus.tick_o), 0);
    chk("rst_clr", int'(bus.clr_o), 0);
    chk("rst_inc", int'(bus.inc_o), 0);
    chk("rst_edit", int'(bus.edit_o), 0);
    chk("rst_blink", int'(bus.blink_o), 0);
    rstn = 1'b0;
    settle(50);
    chk("idle_run", int'(bus.run_o), 0);
    chk("idle_edit", int'(bus.edit_o), 0);
    // start: run_o rises exactly at E0+6, first tick one cycle after entry
    @(negedge clk) bus.start_stop_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_e5", int'(bus.run_o), 0);
    @(negedge clk);
    chk("run_e6", int'(bus.run_o), 1);
    chk("tick_entry", int'(bus.tick_o), 0);
    @(negedge clk) chk("tick_first", int'(bus.tick_o), 1);
    @(negedge clk) chk("tick_gap", int'(bus.tick_o), 0);
    @(negedge clk) chk("tick_second", int'(bus.tick_o), 1);
    bus.start_stop_i = 1'b1;
    settle(20);
    @(negedge clk) bus.start_stop_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("stop_e5", int'(bus.run_o), 1);
    @(negedge clk);
    chk("stop_e6", int'(bus.run_o), 0);
    repeat (3) @(negedge clk);
    bus.start_stop_i = 1'b1;
    t0 = ntick;
    settle(20);
    chk("no_tick_stop", ntick - t0, 0);
    // glitch shorter than the debounce window is ignored
    hold(1, 3);
    settle(15);
    chk("glitch_edit", int'(bus.edit_o), 0);
    hold(1, 6);
    settle(15);
    chk("edit0", int'(bus.edit_o), 1);
    i0 = ninc;
    for (int k = 0; k < 3; k++) begin hold(2, 6); settle(12); end
    chk("inc_count", ninc - i0, 3);
    for (int k = 0; k < 4; k++) begin
      hold(1, 6);
      settle(12);
      chk("edit_walk", int'(bus.edit_o), exp_edit[k]);
      chk("walk_run", int'(bus.run_o), 0);
    end
    // start_stop wins over set in the same cycle
    @(negedge clk) begin bus.start_stop_i = 1'b0; bus.set_i = 1'b0; end
    repeat (6) @(negedge clk);
    bus.start_stop_i = 1'b1;
    bus.set_i = 1'b1;
    settle(12);
    chk("prio_run", int'(bus.run_o), 1);
    chk("prio_edit", int'(bus.edit_o), 0);
    c0 = nclr; i0 = ninc;
    hold(2, 6);
    settle(12);
    chk("run_chg_clr", nclr - c0, 0);
    chk("run_chg_inc", ninc - i0, 0);
    hold(0, 6);
    settle(12);
    chk("stopped", int'(bus.run_o), 0);
    c0 = nclr;
    hold(2, 6);
    settle(12);
    chk("clr_count", nclr - c0, 1);
    // asynchronous reset in the middle of RUN
    hold(0, 6);
    settle(12);
    chk("rerun", int'(bus.run_o), 1);
    @(negedge clk);
    #2 rstn = 1'b1;
    #1;
    chk("async_run", int'(bus.run_o), 0);
    chk("async_tick", int'(bus.tick_o), 0);
    @(negedge clk) rstn = 1'b0;
    settle(5);
    hold(1, 6);
    settle(12);
    found = 0;
    @(negedge clk) bus.set_i = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.edit_o == 4'b0010;
    end
    bus.set_i = 1'b1;
    chk("wait_edit1", int'(found), 1);
    chk("blink_entry", int'(bus.blink_o), BL);
    repeat (2) @(negedge clk);
    chk("blink_x2", int'(bus.blink_o), BL);
    @(negedge clk);
    chk("blink_x3", int'(bus.blink_o), 0);
    for (int k = 0; k < 3; k++) begin hold(1, 6); settle(12); end
    chk("final_edit", int'(bus.edit_o), 0);
    chk("final_blink", int'(bus.blink_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
